dmem_byte_if: RTL and testbench

DMEM_BYTE_IF -- requirements
Module: dmem_byte_if

---
 rtl/dmem_byte_if.sv | 169 ++++++++++++++++
 tb/tb_dmem_byte_if.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_byte_if.sv
// Byte-serialising data-memory interface: splits a word-wide mem-stage access
// into one byte-wide RAM cycle per enabled lane, stalling the pipeline meanwhile.
module dmem_byte_if (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_hold_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq_o,
    output logic [31:0] ram_addr_o,
    output logic        ram_we_o,
    output logic [7:0]  ram_wdata_o,
    input  logic [7:0]  ram_rdata_i
);

    localparam int unsigned AW    = 32;
    localparam int unsigned LANES = 4;
    localparam int unsigned BW    = 8;
    localparam int unsigned IW    = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        DONE    = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [AW-1:IW]           base_q,  base_d;
    logic [LANES-1:0]         sel_q,   sel_d;
    logic [LANES-1:0][BW-1:0] data_q,  data_d;
    logic [LANES-1:0][BW-1:0] buf_q,   buf_d;
    logic [IW-1:0]            idx_q,   idx_d;

    logic                     nxt_found;
    logic [IW-1:0]            nxt_idx;

    // Byte offset within the word is implied by the lane enables.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^mem_addr_i[IW-1:0];

    // Lowest enabled lane of a request.
    function automatic logic [IW-1:0] first_lane(input logic [LANES-1:0] sel);
        logic [IW-1:0] lane;
        logic          found;
        lane  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (!found && sel[IW'(k)]) begin
                lane  = IW'(k);
                found = 1'b1;
            end
        end
        return lane;
    endfunction

    // Next enabled lane strictly above idx; MSB flags whether one exists.
    function automatic logic [IW:0] next_lane(input logic [LANES-1:0] sel,
                                              input logic [IW-1:0]    idx);
        logic [IW-1:0] lane;
        logic          found;
        lane  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (!found && sel[IW'(k)] && (IW'(k) > idx)) begin
                lane  = IW'(k);
                found = 1'b1;
            end
        end
        return {found, lane};
    endfunction

    // Lane stepping within the captured word; 2-bit index so no carry into base.
    assign {nxt_found, nxt_idx} = next_lane(sel_q, idx_q);

    // Next-state, datapath updates and state-decoded outputs.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        sel_d       = sel_q;
        data_d      = data_q;
        buf_d       = buf_q;
        idx_d       = idx_q;
        stallreq_o  = 1'b0;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_wdata_o = '0;
        mem_data_o  = '0;

        unique case (state_q)
            IDLE: begin
                if (mem_ce_i && (mem_sel_i != '0)) begin
                    stallreq_o = 1'b1;
                    base_d     = mem_addr_i[AW-1:IW];
                    sel_d      = mem_sel_i;
                    data_d     = mem_data_i;
                    buf_d      = '0;
                    idx_d      = first_lane(mem_sel_i);
                    state_d    = mem_we_i ? WR : RD_ADDR;
                end
            end

            WR: begin
                stallreq_o  = 1'b1;
                ram_addr_o  = {base_q, idx_q};
                ram_we_o    = 1'b1;
                ram_wdata_o = data_q[idx_q];
                if (nxt_found) begin
                    idx_d = nxt_idx;
                end else begin
                    state_d = DONE;
                end
            end

            RD_ADDR: begin
                stallreq_o = 1'b1;
                ram_addr_o = {base_q, idx_q};
                state_d    = RD_DATA;
            end

            RD_DATA: begin
                stallreq_o    = 1'b1;
                buf_d[idx_q]  = ram_rdata_i;
                if (nxt_found) begin
                    idx_d   = nxt_idx;
                    state_d = RD_ADDR;
                end else begin
                    state_d = DONE;
                end
            end

            DONE: begin
                mem_data_o = buf_q;
                if (!mem_hold_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            buf_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_dmem_byte_if.sv
// Scoreboard bench for dmem_byte_if with a byte-wide synchronous RAM model.
module tb_dmem_byte_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic        mem_hold_i;
    logic [31:0] mem_data_o;
    logic        stallreq_o;
    logic [31:0] ram_addr_o;
    logic        ram_we_o;
    logic [7:0]  ram_wdata_o;
    logic [7:0]  ram_rdata_i;

    logic [7:0]  ram     [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic [39:0] wr_q [$];
    logic [31:0] rd_q [$];
    int          acc_cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    dmem_byte_if dut (
        .clk         (clk),
        .rst         (rst),
        .mem_ce_i    (mem_ce_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_sel_i   (mem_sel_i),
        .mem_data_i  (mem_data_i),
        .mem_hold_i  (mem_hold_i),
        .mem_data_o  (mem_data_o),
        .stallreq_o  (stallreq_o),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Byte RAM: read data valid the cycle after the address.
    always @(posedge clk) begin
        ram_rdata_i <= ram[ram_addr_o[9:0]];
        if (ram_we_o) ram[ram_addr_o[9:0]] = ram_wdata_o;
    end

    // Write scoreboard and RAM-access counter, sampled mid-cycle.
    always @(negedge clk) begin
        if (ram_we_o || (ram_addr_o != 32'h0)) acc_cnt++;
        if (ram_we_o) begin
            if (wr_q.size() == 0) check_eq("wr_spurious", {ram_addr_o, ram_wdata_o}, 40'h0);
            else                  check_eq("wr", {ram_addr_o, ram_wdata_o}, wr_q.pop_front());
        end
    end

    task automatic run_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                              input logic [31:0] data, input int hold_extra);
        int          n;
        int          stalls;
        int          acc0;
        int          guard;
        logic [31:0] exp_rd;
        logic [31:0] got_rd;
        logic [9:0]  base;
        n      = 0;
        exp_rd = '0;
        base   = {addr[9:2], 2'b00};
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) begin
                n++;
                if (we) begin
                    wr_q.push_back({{22'h0, base + 10'(k)}, data[8*k +: 8]});
                    ref_mem[base + 10'(k)] = data[8*k +: 8];
                end else begin
                    exp_rd[8*k +: 8] = ref_mem[base + 10'(k)];
                end
            end
        end
        rd_q.push_back(exp_rd);

        @(negedge clk);
        mem_ce_i   = 1'b1;
        mem_we_i   = we;
        mem_addr_i = addr;
        mem_sel_i  = sel;
        mem_data_i = data;
        mem_hold_i = (hold_extra > 0);
        #1;
        acc0   = acc_cnt;
        stalls = stallreq_o ? 1 : 0;
        guard  = 0;
        while (stallreq_o && guard < 40) begin
            @(negedge clk); #1;
            mem_ce_i   = 1'b0;
            mem_addr_i = $urandom();
            mem_data_i = $urandom();
            guard++;
            if (stallreq_o) stalls++;
        end
        mem_ce_i = 1'b0;
        check_eq("done_reached", 40'(guard < 40), 40'(1));
        check_eq("stall_cycles", 40'(stalls), 40'(we ? 1 + n : 1 + 2 * n));
        got_rd = rd_q.pop_front();
        check_eq("rdata", 40'(mem_data_o), 40'(got_rd));
        check_eq("ram_accesses", 40'(acc_cnt - acc0), 40'(n));
        for (int h = 0; h < hold_extra; h++) begin
            @(negedge clk); #1;
            check_eq("hold_stall", 40'(stallreq_o), 40'(0));
            check_eq("hold_rdata", 40'(mem_data_o), 40'(got_rd));
            check_eq("hold_accesses", 40'(acc_cnt - acc0), 40'(n));
        end
        mem_hold_i = 1'b0;
        @(negedge clk); #1;
        check_eq("idle_rdata_zero", 40'(mem_data_o), 40'(0));
        check_eq("wr_queue_empty", 40'(wr_q.size()), 40'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          a0;
        logic        rw;
        logic [31:0] ra;
        logic [3:0]  rs;

        for (int i = 0; i < 1024; i++) begin
            ram[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        ram[10'h203] = 8'hA5; ref_mem[10'h203] = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            ram[10'h40 + 10'(i)]     = 8'(i + 1);
            ref_mem[10'h40 + 10'(i)] = 8'(i + 1);
            ram[10'h300 + 10'(i)]    = 8'h5A;
            ref_mem[10'h300 + 10'(i)] = 8'h5A;
        end

        rst        = 1'b0;
        mem_ce_i   = 1'b0;
        mem_we_i   = 1'b0;
        mem_addr_i = '0;
        mem_sel_i  = '0;
        mem_data_i = '0;
        mem_hold_i = 1'b0;
        #3;
        check_eq("rst_stall", 40'(stallreq_o), 40'(0));
        check_eq("rst_we", 40'(ram_we_o), 40'(0));
        check_eq("rst_addr", 40'(ram_addr_o), 40'(0));
        check_eq("rst_wdata", 40'(ram_wdata_o), 40'(0));
        check_eq("rst_rdata", 40'(mem_data_o), 40'(0));
        @(negedge clk);
        rst = 1'b1;

        run_access(1'b1, 32'h100, 4'b1111, 32'h11223344, 0);  // SW
        run_access(1'b0, 32'h203, 4'b1000, 32'h0, 0);         // LB
        run_access(1'b1, 32'h102, 4'b1100, 32'hBEEFBEEF, 0);  // SH upper half
        check_eq("sh_lane0_kept", 40'(ram[10'h100]), 40'(8'h44));
        check_eq("sh_lane1_kept", 40'(ram[10'h101]), 40'(8'h33));
        run_access(1'b0, 32'h40, 4'b1111, 32'h0, 0);          // LW
        run_access(1'b0, 32'h101, 4'b0010, 32'h0, 2);         // LB held 3 DONE cycles
        run_access(1'b1, 32'h204, 4'b0101, 32'hCAFEF00D, 0);  // sparse store
        run_access(1'b0, 32'h204, 4'b1111, 32'h0, 0);
        run_access(1'b0, 32'h100, 4'b1010, 32'h0, 0);         // sparse load

        // Request with no lanes enabled is ignored.
        @(negedge clk);
        mem_ce_i  = 1'b1;
        mem_sel_i = 4'b0000;
        mem_addr_i = 32'h100;
        #1;
        a0 = acc_cnt;
        check_eq("sel0_stall", 40'(stallreq_o), 40'(0));
        repeat (2) @(negedge clk);
        #1;
        check_eq("sel0_stall_later", 40'(stallreq_o), 40'(0));
        check_eq("sel0_accesses", 40'(acc_cnt - a0), 40'(0));
        mem_ce_i = 1'b0;

        // Reset after the second byte of a SW.
        wr_q.push_back({32'h300, 8'hD4});
        wr_q.push_back({32'h301, 8'hC3});
        ref_mem[10'h300] = 8'hD4;
        ref_mem[10'h301] = 8'hC3;
        @(negedge clk);
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b1;
        mem_addr_i = 32'h300;
        mem_sel_i  = 4'b1111;
        mem_data_i = 32'hA1B2C3D4;
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_rst_we", 40'(ram_we_o), 40'(1));
        rst      = 1'b0;
        mem_ce_i = 1'b0;
        #1;
        check_eq("rst_mid_we", 40'(ram_we_o), 40'(0));
        check_eq("rst_mid_addr", 40'(ram_addr_o), 40'(0));
        check_eq("rst_mid_stall", 40'(stallreq_o), 40'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        check_eq("post_rst_stall", 40'(stallreq_o), 40'(0));
        check_eq("post_rst_rdata", 40'(mem_data_o), 40'(0));
        check_eq("lane2_untouched", 40'(ram[10'h302]), 40'(8'h5A));
        check_eq("lane3_untouched", 40'(ram[10'h303]), 40'(8'h5A));
        check_eq("rst_wr_queue", 40'(wr_q.size()), 40'(0));
        run_access(1'b0, 32'h300, 4'b1111, 32'h0, 0);

        // Random mixed traffic.
        for (int t = 0; t < 20; t++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 32'h80 + 32'($urandom_range(0, 32'h37F));
            rs = 4'($urandom_range(1, 15));
            run_access(rw, ra, rs, $urandom(), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
